// File: rtl/laser_frame_sched.sv
// Round-robin frame scheduler in front of one LASER two-circle engine: buffers a 40-point frame,
// streams it into the engine and returns the centres. Optional WAIT abort under LASER_SCHED_TIMEOUT_EN.
module laser_frame_sched #(
  parameter int NPTS   = 40,
  parameter int DATA_W = 4
`ifdef LASER_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 2047
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ0,
  input  logic              REQ1,
  output logic              GNT0,
  output logic              GNT1,
  input  logic              PT_VALID,
  input  logic [DATA_W-1:0] PT_X,
  input  logic [DATA_W-1:0] PT_Y,
  output logic              PT_READY,
  output logic              RES_VALID,
  output logic              RES_ID,
  output logic [DATA_W-1:0] RES_C1X,
  output logic [DATA_W-1:0] RES_C1Y,
  output logic [DATA_W-1:0] RES_C2X,
  output logic [DATA_W-1:0] RES_C2Y,
  output logic              RES_ERR,
  output logic              CORE_RST,
  output logic [DATA_W-1:0] CORE_X,
  output logic [DATA_W-1:0] CORE_Y,
  input  logic              CORE_DONE,
  input  logic [DATA_W-1:0] CORE_C1X,
  input  logic [DATA_W-1:0] CORE_C1Y,
  input  logic [DATA_W-1:0] CORE_C2X,
  input  logic [DATA_W-1:0] CORE_C2Y
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STREAM, S_WAIT, S_RESULT} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NPTS - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_last;
  logic              r_owner;
  logic [5:0]        r_idx;
  logic [DATA_W-1:0] r_buf_x [NPTS];
  logic [DATA_W-1:0] r_buf_y [NPTS];
  logic [DATA_W-1:0] r_core_x, r_core_y;
  logic [DATA_W-1:0] r_c1x, r_c1y, r_c2x, r_c2y;
  logic              w_any_req;
  logic              w_grant1;
  logic              w_accept;
  logic              w_load_done;
  logic              w_stream_done;
  logic              w_finish;
  logic              w_timeout;

  assign w_any_req     = REQ0 | REQ1;
  // The requester that did not win last time has priority; otherwise the sole requester wins.
  assign w_grant1      = r_last ? ~REQ0 : REQ1;
  assign w_accept      = (r_state == S_LOAD) && PT_VALID;
  assign w_load_done   = w_accept && (r_idx == LAST_IDX);
  assign w_stream_done = (r_state == S_STREAM) && (r_idx == LAST_IDX);
  assign w_finish      = (r_state == S_WAIT) && (CORE_DONE || w_timeout);

`ifdef LASER_SCHED_TIMEOUT_EN
  logic [11:0] r_wait_cnt;
  logic        r_err;

  assign w_timeout = (r_state == S_WAIT) && !CORE_DONE && (r_wait_cnt == 12'(TIMEOUT_CYC - 1));
  assign RES_ERR   = r_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 12'd1 : 12'd0;
      if (w_finish) r_err <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign RES_ERR   = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any_req)     w_next = S_LOAD;
      S_LOAD:   if (w_load_done)   w_next = S_STREAM;
      S_STREAM: if (w_stream_done) w_next = S_WAIT;
      S_WAIT:   if (w_finish)      w_next = S_RESULT;
      S_RESULT:                    w_next = S_IDLE;
      default:                     w_next = S_IDLE;
    endcase
  end

  always_comb begin
    GNT0      = (r_state == S_LOAD) && !r_owner;
    GNT1      = (r_state == S_LOAD) &&  r_owner;
    PT_READY  = (r_state == S_LOAD);
    RES_VALID = (r_state == S_RESULT);
    // Engine runs only while streaming/waiting; a timeout re-asserts its reset immediately.
    CORE_RST  = !((r_state == S_STREAM) || ((r_state == S_WAIT) && !w_timeout));
  end

  assign RES_ID  = r_owner;
  assign RES_C1X = r_c1x;
  assign RES_C1Y = r_c1y;
  assign RES_C2X = r_c2x;
  assign RES_C2Y = r_c2y;
  assign CORE_X  = r_core_x;
  assign CORE_Y  = r_core_y;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_idx    <= '0;
      r_core_x <= '0;
      r_core_y <= '0;
      r_c1x    <= '0;
      r_c1y    <= '0;
      r_c2x    <= '0;
      r_c2y    <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_any_req) begin
        r_owner <= w_grant1;
        r_last  <= w_grant1;
      end
      if (w_accept || (r_state == S_STREAM))
        r_idx <= (r_idx == LAST_IDX) ? 6'd0 : r_idx + 6'd1;
      // CORE_X/Y are registered, so each point is fetched one cycle ahead of its STREAM slot.
      if (w_load_done) begin
        r_core_x <= r_buf_x[0];
        r_core_y <= r_buf_y[0];
      end else if ((r_state == S_STREAM) && !w_stream_done) begin
        r_core_x <= r_buf_x[r_idx + 6'd1];
        r_core_y <= r_buf_y[r_idx + 6'd1];
      end else begin
        r_core_x <= '0;
        r_core_y <= '0;
      end
      if (w_finish) begin
        r_c1x <= w_timeout ? '0 : CORE_C1X;
        r_c1y <= w_timeout ? '0 : CORE_C1Y;
        r_c2x <= w_timeout ? '0 : CORE_C2X;
        r_c2y <= w_timeout ? '0 : CORE_C2Y;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_buf_x[r_idx] <= PT_X;
      r_buf_y[r_idx] <= PT_Y;
    end
  end

endmodule

// File: tb/tb_laser_frame_sched.sv
// Randomized bench for laser_frame_sched: drives requesters and a stand-in engine, checks against
// a frame-level reference model (round-robin owner, stored points, captured centres).
module tb_laser_frame_sched;
  localparam int NPTS   = 40;
  localparam int TO_CYC = 100;

  logic       CLK = 1'b0;
  logic       RST, REQ0, REQ1, PT_VALID, CORE_DONE;
  logic [3:0] PT_X, PT_Y, CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y;
  logic       GNT0, GNT1, PT_READY, RES_VALID, RES_ID, RES_ERR, CORE_RST;
  logic [3:0] RES_C1X, RES_C1Y, RES_C2X, RES_C2Y, CORE_X, CORE_Y;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         m_last;
  logic [3:0] ex [NPTS];
  logic [3:0] ey [NPTS];

  always #5 CLK = ~CLK;

  laser_frame_sched #(
    .NPTS(NPTS)
`ifdef LASER_SCHED_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .GNT0(GNT0), .GNT1(GNT1),
    .PT_VALID(PT_VALID), .PT_X(PT_X), .PT_Y(PT_Y), .PT_READY(PT_READY),
    .RES_VALID(RES_VALID), .RES_ID(RES_ID), .RES_C1X(RES_C1X), .RES_C1Y(RES_C1Y),
    .RES_C2X(RES_C2X), .RES_C2Y(RES_C2Y), .RES_ERR(RES_ERR), .CORE_RST(CORE_RST),
    .CORE_X(CORE_X), .CORE_Y(CORE_Y), .CORE_DONE(CORE_DONE), .CORE_C1X(CORE_C1X),
    .CORE_C1Y(CORE_C1Y), .CORE_C2X(CORE_C2X), .CORE_C2Y(CORE_C2Y)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_gnt"},   32'({GNT1, GNT0}), 0);
    chk({tag, "_ready"}, 32'(PT_READY), 0);
    chk({tag, "_resv"},  32'(RES_VALID), 0);
    chk({tag, "_resid"}, 32'(RES_ID), 0);
    chk({tag, "_resc"},  32'({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 0);
    chk({tag, "_err"},   32'(RES_ERR), 0);
    chk({tag, "_crst"},  32'(CORE_RST), 1);
    chk({tag, "_cxy"},   32'({CORE_X, CORE_Y}), 0);
  endtask

  task automatic pulse_reset();
    CORE_DONE = 1'b0; PT_VALID = 1'b0; REQ0 = 1'b0; REQ1 = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    m_last = 1'b1;
  endtask

  // One complete frame transaction, starting at a negedge with the DUT in IDLE.
  task automatic do_frame(input bit r0, input bit r1, input bit drop_req, input bit toggle,
                          input bit stray, input int abort_at, input bit no_done, input bit pat);
    int         waits, n, lat, nres;
    bit         exp_own, vphase;
    logic [3:0] c1x, c1y, c2x, c2y;
    if (r0 && r1) exp_own = ~m_last;
    else          exp_own = r1;
    m_last = exp_own;
    for (int i = 0; i < NPTS; i++) begin
      ex[i] = pat ? 4'(i % 16)      : 4'($urandom);
      ey[i] = pat ? 4'(15 - i % 16) : 4'($urandom);
    end
    REQ0 = r0; REQ1 = r1;
    waits = 0;
    do begin
      @(negedge CLK);
      waits++;
    end while (!(GNT0 | GNT1) && waits < 4);
    chk("gnt_latency", waits, 1);
    chk("gnt_owner", 32'({GNT1, GNT0}), exp_own ? 2 : 1);
    if (drop_req) begin REQ0 = 1'b0; REQ1 = 1'b0; end
    n = 0; vphase = 1'b0;
    while (n < NPTS && waits < 200) begin
      waits++;
      chk("load_ready", 32'(PT_READY), 1);
      chk("load_gnt", 32'({GNT1, GNT0}), exp_own ? 2 : 1);
      chk("load_resv", 32'(RES_VALID), 0);
      vphase   = toggle ? ~vphase : 1'b1;
      PT_VALID = vphase;
      PT_X     = vphase ? ex[n] : 4'($urandom);
      PT_Y     = vphase ? ey[n] : 4'($urandom);
      CORE_DONE = stray && ($urandom_range(0, 3) == 0);
      CORE_C1X  = 4'($urandom);
      if (vphase) n++;
      @(negedge CLK);
    end
    PT_VALID = 1'b0;
    chk("str_gnt_drop", 32'({GNT1, GNT0, PT_READY}), 0);
    for (int k = 0; k < NPTS; k++) begin
      chk("str_crst", 32'(CORE_RST), 0);
      chk("str_x", 32'(CORE_X), 32'(ex[k]));
      chk("str_y", 32'(CORE_Y), 32'(ey[k]));
      chk("str_resv", 32'(RES_VALID), 0);
      if (k == abort_at) begin
        pulse_reset();
        chk_reset_outs("abort");
        return;
      end
      CORE_DONE = stray && ($urandom_range(0, 3) == 0);
      @(negedge CLK);
    end
    CORE_DONE = 1'b0;
    if (no_done) begin
`ifdef LASER_SCHED_TIMEOUT_EN
      waits = 0;
      while (!RES_VALID && waits < 400) begin
        chk("to_crst", 32'(CORE_RST), (waits == TO_CYC - 1) ? 1 : 0);
        waits++;
        @(negedge CLK);
      end
      chk("to_wait_cycles", waits, TO_CYC);
      chk("to_resv", 32'(RES_VALID), 1);
      chk("to_err", 32'(RES_ERR), 1);
      chk("to_resid", 32'(RES_ID), 32'(exp_own));
      chk("to_resc", 32'({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 0);
      @(negedge CLK);
      chk("to_pulse", 32'(RES_VALID), 0);
`else
      nres = 0;
      for (int j = 0; j < 300; j++) begin
        if (RES_VALID) nres++;
        @(negedge CLK);
      end
      chk("noto_resv_count", nres, 0);
      chk("noto_crst", 32'(CORE_RST), 0);
      pulse_reset();
      chk_reset_outs("noto_rst");
`endif
      return;
    end
    lat = $urandom_range(1, 8);
    for (int j = 0; j < lat; j++) begin
      chk("wait_crst", 32'(CORE_RST), 0);
      chk("wait_xy", 32'({CORE_X, CORE_Y}), 0);
      chk("wait_resv", 32'(RES_VALID), 0);
      @(negedge CLK);
    end
    c1x = 4'($urandom); c1y = 4'($urandom); c2x = 4'($urandom); c2y = 4'($urandom);
    CORE_DONE = 1'b1;
    CORE_C1X = c1x; CORE_C1Y = c1y; CORE_C2X = c2x; CORE_C2Y = c2y;
    @(negedge CLK);
    CORE_DONE = 1'b0;
    CORE_C1X = ~c1x; CORE_C1Y = ~c1y; CORE_C2X = ~c2x; CORE_C2Y = ~c2y;
    chk("res_valid", 32'(RES_VALID), 1);
    chk("res_id", 32'(RES_ID), 32'(exp_own));
    chk("res_err", 32'(RES_ERR), 0);
    chk("res_crst", 32'(CORE_RST), 1);
    chk("res_centres", 32'({RES_C1X, RES_C1Y, RES_C2X, RES_C2Y}), 32'({c1x, c1y, c2x, c2y}));
    @(negedge CLK);
    chk("res_pulse", 32'(RES_VALID), 0);
    chk("gnt_after_res", 32'({GNT1, GNT0}), 0);
  endtask

  initial begin
    bit r0, r1;
    RST = 1'b1; REQ0 = 1'b0; REQ1 = 1'b0; PT_VALID = 1'b0; PT_X = '0; PT_Y = '0;
    CORE_DONE = 1'b0; CORE_C1X = '0; CORE_C1Y = '0; CORE_C2X = '0; CORE_C2Y = '0;
    repeat (3) @(negedge CLK);
    chk_reset_outs("rst");
    RST = 1'b0;
    m_last = 1'b1;

    do_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b1);

    pulse_reset();
    for (int i = 0; i < 3; i++)
      do_frame(1'b1, 1'b1, (i == 2), 1'b0, 1'b0, -1, 1'b0, 1'b0);

    do_frame(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b0);

    do_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 20, 1'b0, 1'b0);
    repeat (3) begin
      chk("post_abort_resv", 32'(RES_VALID), 0);
      @(negedge CLK);
    end
    do_frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      r0 = 1'($urandom);
      r1 = r0 ? 1'($urandom) : 1'b1;
      do_frame(r0, r1, 1'b1, 1'($urandom), 1'($urandom), -1, 1'b0, 1'b0);
    end

    do_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_frame_sched.md
# laser_frame_sched

Front-end scheduler for the LASER two-circle coverage engine. It arbitrates round-robin between two frame requesters, buffers one 40-point frame, then sequences the engine: holds it in reset, streams the frame in on 40 back-to-back cycles, waits for DONE, and returns the two circle centres tagged with the requester ID. It sits between the point-producing clients and a single LASER instance, and is the only driver of that engine's RST, X and Y.

## Interface
- NPTS, 40, points per frame; the engine is fixed at 40
- TIMEOUT_CYC, 2047, maximum WAIT cycles before abort (used only with LASER_SCHED_TIMEOUT_EN)

- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- REQ0, REQ1  in  1 each  frame request from requester 0 / 1
- GNT0, GNT1  out  1 each  grant; at most one high
- PT_VALID  in  1  point valid from the granted requester
- PT_X, PT_Y  in  4 each  point coordinates
- PT_READY  out  1  point accepted when PT_VALID & PT_READY
- RES_VALID  out  1  one-cycle result strobe
- RES_ID  out  1  requester that owns the result
- RES_C1X, RES_C1Y, RES_C2X, RES_C2Y  out  4 each  circle centres
- RES_ERR  out  1  result aborted by timeout
- CORE_RST  out  1  engine reset
- CORE_X, CORE_Y  out  4 each  engine point inputs
- CORE_DONE  in  1  engine done
- CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y  in  4 each  engine outputs

## Operation
- Storage: 40x4b X buffer, 40x4b Y buffer; 6-bit point index; 1-bit round-robin pointer `last` (reset 1, so requester 0 wins first).
- States: IDLE, LOAD, STREAM, WAIT, RESULT.
- IDLE: if REQ0|REQ1, grant the requester other than `last` if it requests, else the sole requester; set `last`; go LOAD. REQ is sampled only in IDLE.
- LOAD: GNT of the owner high, PT_READY high; each handshake writes buffer[index] and increments index. On the accept with index==39: index clears, GNT/PT_READY drop, go STREAM.
- STREAM: CORE_RST low; CORE_X/Y = buffer[index], index 0..39 over 40 consecutive cycles with no stall. After index 39, go WAIT.
- WAIT: CORE_RST low, CORE_X/Y = 0. On CORE_DONE=1, capture CORE_C*; go RESULT.
- RESULT: RES_VALID=1 for exactly one cycle with captured values, RES_ID=owner, RES_ERR=0; go IDLE.
- CORE_RST is high in IDLE, LOAD and RESULT, and low only in STREAM and WAIT, so the engine never reads unowned data after its OUTPUT state.
- CORE_DONE outside WAIT is ignored. REQ deassertion during LOAD does not abort; the grant is held until 40 points are received.
- RST at any point, including mid-LOAD or mid-STREAM: the partial frame is discarded, no RES_VALID is issued, and all state returns to reset values.

## Timing
- Reset values: GNT0=GNT1=0, PT_READY=0, RES_VALID=0, RES_ID=0, RES_C*=0, RES_ERR=0, CORE_RST=1, CORE_X=CORE_Y=0.
- GNT rises on the cycle after REQ is sampled in IDLE.
- Engine samples point 0 on the first cycle CORE_RST is low; CORE_X/Y are registered, so point k is presented on STREAM cycle k.
- RES_VALID is asserted the cycle after CORE_DONE is seen.
- Minimum IDLE-to-IDLE time is 1 + 40 (LOAD at full rate) + 40 (STREAM) + engine latency + 1 cycles.
- Next GNT can be no earlier than the cycle after RESULT.

## Configuration
- LASER_SCHED_TIMEOUT_EN defined: a 12-bit WAIT counter clears on WAIT entry. If it reaches TIMEOUT_CYC without CORE_DONE, go RESULT with RES_ERR=1 and RES_C*=0. CORE_RST is forced high that cycle.
- Not defined: no counter; WAIT waits forever; RES_ERR is tied 0.

## Test plan
- REQ0 only, points (i mod 16, 15 - i mod 16) at full rate -> GNT0 on the next cycle, 40 accepts, CORE_X/Y match on 40 consecutive cycles with CORE_RST=0; DONE from model -> RES_VALID pulse one cycle later, RES_ID=0, centres equal model values.
- REQ0 and REQ1 high together from reset, both kept high -> grants alternate 0,1,0; never both high.
- PT_VALID toggling every other cycle in LOAD -> exactly 40 points stored in order; STREAM output unchanged and contiguous.
- CORE_DONE pulsed during LOAD and STREAM -> ignored, no RES_VALID.
- RST at STREAM cycle 20 -> all outputs at reset values next cycle, no RES_VALID; a new REQ1 completes normally.
- With LASER_SCHED_TIMEOUT_EN and TIMEOUT_CYC=100, CORE_DONE held low -> RES_VALID with RES_ERR=1 and centres 0 after 100 WAIT cycles; without the macro -> RES_VALID never asserts.
